// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t        : controller states (IDLE, BUSY, DONE)
//   DEFAULT_WIDTH  : default operand width
//   count_width()  : width of the step counter for a given operand width
//   prod_width()   : product width for a given operand width
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter runs 0..w-1; keep at least one bit for tiny widths.
  function automatic int count_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational iteration of the shift-and-add multiplier.
// Ports:
//   acc      (in,  2*WIDTH) : accumulator {partial high half, remaining multiplier bits}
//   mcand    (in,  WIDTH)   : multiplicand
//   acc_next (out, 2*WIDTH) : accumulator after add-if-lsb and right shift
module shift_add_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [prod_width(WIDTH)-1:0] acc,
  input  logic [WIDTH-1:0]             mcand,
  output logic [prod_width(WIDTH)-1:0] acc_next
);

  // WIDTH+1 bits so the adder carry survives and becomes the new MSB.
  logic [WIDTH:0] hi;

  always_comb begin
    hi = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      hi = hi + {1'b0, mcand};
    end
    acc_next = {hi, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH unsigned shift-and-add multiplier.
// Operands are accepted in IDLE over a valid/ready handshake; the product is
// available WIDTH cycles later and held in DONE until the consumer accepts it.
// Optional macro SEQ_MUL_SIGNED_EN adds io_signed: two's complement operands
// are multiplied by magnitude and the product negated on DONE entry.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   io_in_valid   : operand pair valid        io_in_ready  : accepting (IDLE)
//   io_a, io_b    : multiplicand, multiplier  io_signed    : signed mode (macro only)
//   io_out_valid  : product valid             io_out_ready : consumer accepts
//   io_result     : 2*WIDTH product           io_busy      : BUSY or DONE
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WIDTH-1:0]     io_a,
  input  logic [WIDTH-1:0]     io_b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 io_signed,
`endif
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [2*WIDTH-1:0]   io_result,
  output logic                 io_busy
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    final_product;

`ifdef SEQ_MUL_SIGNED_EN
  logic negate;
  logic neg_in;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  always_comb begin
    a_mag  = (io_signed && io_a[WIDTH-1]) ? (~io_a + 1'b1) : io_a;
    b_mag  = (io_signed && io_b[WIDTH-1]) ? (~io_b + 1'b1) : io_b;
    neg_in = io_signed && (io_a[WIDTH-1] ^ io_b[WIDTH-1]);
  end

  always_comb begin
    final_product = negate ? (~acc_next + 1'b1) : acc_next;
  end
`else
  always_comb begin
    a_mag = io_a;
    b_mag = io_b;
  end

  always_comb begin
    final_product = acc_next;
  end
`endif

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      io_in_ready  <= 1'b1;
      io_out_valid <= 1'b0;
      io_busy      <= 1'b0;
      io_result    <= '0;
      count        <= '0;
      acc          <= '0;
      mcand        <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      negate       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid && io_in_ready) begin
            mcand       <= a_mag;
            acc         <= {{WIDTH{1'b0}}, b_mag};
            count       <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            negate      <= neg_in;
`endif
            state       <= BUSY;
            io_in_ready <= 1'b0;
            io_busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          // The last step's result is taken straight from the adder so the
          // product is registered on the same edge that enters DONE.
          if (count == LAST) begin
            state        <= DONE;
            io_out_valid <= 1'b1;
            io_result    <= final_product;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state        <= IDLE;
            io_out_valid <= 1'b0;
            io_busy      <= 1'b0;
            io_in_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          io_in_ready  <= 1'b1;
          io_out_valid <= 1'b0;
          io_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed WIDTH=8 vectors,
// backpressure and mid-operation reset sequences, plus random scoreboarded
// streams on WIDTH=4, 8 and 16 instances against an arithmetic reference.
module tb_seq_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer arithmetic on the interpreted operands.
  function automatic longint unsigned ref_mul(input int w, input longint unsigned a,
                                              input longint unsigned b, input bit sgn);
    longint sa;
    longint sb;
    longint p;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return longint'(p) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // ---------------- directed WIDTH=8 instance ----------------
  logic        d_rst, d_valid, d_iready, d_ovalid, d_oready, d_busy, d_sgn;
  logic [7:0]  d_a, d_b;
  logic [15:0] d_result;

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut (
    .clock        (clk),
    .reset        (d_rst),
    .io_in_valid  (d_valid),
    .io_in_ready  (d_iready),
    .io_a         (d_a),
    .io_b         (d_b),
`ifdef SEQ_MUL_SIGNED_EN
    .io_signed    (d_sgn),
`endif
    .io_out_valid (d_ovalid),
    .io_out_ready (d_oready),
    .io_result    (d_result),
    .io_busy      (d_busy)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  // Issues one operand pair (starting at a negedge) and checks latency,
  // product and return to IDLE; io_out_ready is expected high.
  task automatic run_vec(input vec_t v, input string name);
    int unsigned n;
    n = 0;
    while (!d_iready && n < 50) begin
      @(negedge clk);
      n++;
    end
    d_a = v.a; d_b = v.b; d_sgn = v.sgn; d_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    d_a = ~v.a; d_b = ~v.b;
    chk({name, "_busy"}, d_busy, 1);
    chk({name, "_inready_low"}, d_iready, 0);
    n = 0;
    while (!d_ovalid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, 8);
    chk({name, "_result"}, d_result, v.exp);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_inready_after"}, d_iready, 1);
    chk({name, "_ovalid_after"}, d_ovalid, 0);
  endtask

  // ---------------- random scoreboarded instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;
    logic           rst, valid, iready, ovalid, oready, busy, sgn;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] result;
    bit             fin = 1'b0;

    seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
      .clock        (clk),
      .reset        (rst),
      .io_in_valid  (valid),
      .io_in_ready  (iready),
      .io_a         (a),
      .io_b         (b),
`ifdef SEQ_MUL_SIGNED_EN
      .io_signed    (sgn),
`endif
      .io_out_valid (ovalid),
      .io_out_ready (oready),
      .io_result    (result),
      .io_busy      (busy)
    );

    initial begin
      longint unsigned q[$];
      int unsigned     w;
      bit              got;
      rst = 1'b1; valid = 1'b0; a = '0; b = '0; sgn = 1'b0; oready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 1000; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        // First pair is the all-ones maximum to cover the carry path.
        a = (n == 0) ? '1 : W'($urandom);
        b = (n == 0) ? '1 : W'($urandom);
`ifdef SEQ_MUL_SIGNED_EN
        sgn = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
`else
        sgn = 1'b0;
`endif
        valid = 1'b1;
        w = 0;
        while (!iready && w < 50) begin
          @(negedge clk);
          w++;
        end
        if (!iready) chk($sformatf("w%0d_inready_timeout", W), iready, 1);
        @(posedge clk);
        q.push_back(ref_mul(W, a, b, sgn));
        @(negedge clk);
        valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        got = 1'b0;
        w = 0;
        while (!got && w < 200) begin
          oready = ($urandom_range(0, 3) != 0);
          if (ovalid && oready) begin
            chk($sformatf("w%0d_result_%0d", W, n), result, q.pop_front());
            got = 1'b1;
          end
          @(posedge clk);
          @(negedge clk);
          w++;
        end
        if (!got) chk($sformatf("w%0d_out_timeout_%0d", W, n), ovalid, 1);
      end
      oready = 1'b0;
      fin = 1'b1;
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    vec_t        vecs[$];
    vec_t        v;
    int unsigned t;
    bit          pulse_seen;
    d_rst = 1'b1; d_valid = 1'b0; d_a = '0; d_b = '0; d_sgn = 1'b0; d_oready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_inready", d_iready, 1);
    chk("reset_ovalid", d_ovalid, 0);
    chk("reset_busy", d_busy, 0);
    chk("reset_result", d_result, 0);
    d_rst = 1'b0;

    vecs.push_back('{8'd13,  8'd11,  1'b0, 16'd143});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01});
    vecs.push_back('{8'd0,   8'd200, 1'b0, 16'd0});
    vecs.push_back('{8'd1,   8'd1,   1'b0, 16'd1});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 16'd255});
    vecs.push_back('{8'd128, 8'd2,   1'b0, 16'd256});
    vecs.push_back('{8'd170, 8'd85,  1'b0, 16'd14450});
`ifdef SEQ_MUL_SIGNED_EN
    vecs.push_back('{8'hFD, 8'd7,   1'b1, 16'hFFEB});
    vecs.push_back('{8'h80, 8'h80,  1'b1, 16'h4000});
    vecs.push_back('{8'h7F, 8'h80,  1'b1, 16'hC080});
    vecs.push_back('{8'hFD, 8'd7,   1'b0, 16'd1771});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: product held for 20 cycles, new requests ignored.
    d_oready = 1'b0;
    d_a = 8'd13; d_b = 8'd11; d_sgn = 1'b0; d_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    t = 0;
    while (!d_ovalid && t < 40) begin
      @(posedge clk);
      t++;
      @(negedge clk);
    end
    chk("bp_latency", t, 8);
    for (int i = 0; i < 20; i++) begin
      d_valid = 1'b1;
      d_a = 8'($urandom);
      d_b = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_ovalid_%0d", i), d_ovalid, 1);
      chk($sformatf("bp_result_%0d", i), d_result, 143);
      chk($sformatf("bp_inready_%0d", i), d_iready, 0);
    end
    d_valid = 1'b0;
    d_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ovalid", d_ovalid, 0);
    chk("bp_release_inready", d_iready, 1);
    chk("bp_release_busy", d_busy, 0);
    chk("bp_result_kept", d_result, 143);
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_busy", d_busy, 0);

    // Reset during BUSY cycle 3 aborts the operation.
    d_a = 8'd200; d_b = 8'd199; d_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", d_busy, 1);
    d_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_rst = 1'b0;
    chk("midrst_busy", d_busy, 0);
    chk("midrst_inready", d_iready, 1);
    chk("midrst_ovalid", d_ovalid, 0);
    chk("midrst_result", d_result, 0);
    pulse_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (d_ovalid) pulse_seen = 1'b1;
    end
    chk("midrst_no_pulse", pulse_seen, 0);

    // Wait for the random streams, bounded.
    t = 0;
    while (!(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("random_streams_finished",
        {g_rand[0].fin, g_rand[1].fin, g_rand[2].fin}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
